// File: rtl/sum_dac_pkg.sv
// sum_dac_pkg: shared types, widths and sample scaling for sum_dac_spi.
// Build macro SUM_DAC_ROUND_EN selects round-half-up scaling instead of truncation.
package sum_dac_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int SUM_W   = 13;

  localparam logic [3:0] DEF_DAC_CMD = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  // Map the 13-bit sum onto the 12-bit DAC code
  function automatic logic [DATA_W-1:0] scale_sum(
    input logic [SUM_W-1:0] s
  );
`ifdef SUM_DAC_ROUND_EN
    logic [SUM_W:0] r;
    r = {1'b0, s} + 14'd1;
    if (r[SUM_W])
      scale_sum = '1;
    else
      scale_sum = r[DATA_W:1];
`else
    scale_sum = s[SUM_W-1:1];
`endif
  endfunction

endpackage

// File: rtl/sum_dac_tick.sv
// sum_dac_tick: half-period tick generator for the DAC serial clock.
// Counts CLK_DIV enabled cycles per tick; cleared when a frame starts.
module sum_dac_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // Free-run while enabled, wrap at the end of each half-period
  always_ff @(posedge clk) begin
    if (i_rst || i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/sum_dac_spi.sv
// sum_dac_spi: scales the two-tone sum to 12 bits and shifts it to a serial DAC.
// Build macro SUM_DAC_ROUND_EN selects rounding; default build truncates.
import sum_dac_pkg::*;

module sum_dac_spi #(
  parameter int         CLK_DIV = 2,
  parameter int         GAP_CYC = 2,
  parameter logic [3:0] DAC_CMD = DEF_DAC_CMD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic             dac_cs_n,
  output logic             dac_sclk,
  output logic             dac_sdo,
  output logic             frame_done,
  output logic [7:0]       drop_cnt
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_t r_state;
  state_t w_next;

  logic [FRAME_W-1:0] r_shift;
  logic [3:0]         r_bit;
  logic               r_phase;
  logic [GW-1:0]      r_gap;
  logic               r_done;
  logic [7:0]         r_drop;

  logic w_tick;
  logic w_accept;
  logic w_last_bit;
  logic w_gap_end;
  logic w_shift_en;

  assign w_accept   = (r_state == IDLE) && sum_valid;
  assign w_shift_en = (r_state == SHIFT);
  assign w_last_bit = w_tick && r_phase && (r_bit == 4'd0);
  assign w_gap_end  = (r_state == GAP) && (r_gap == GAP_LAST);

  sum_dac_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .i_rst  (rst),
    .i_en   (w_shift_en),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state and frame-pin decode
  always_comb begin
    w_next    = r_state;
    sum_ready = 1'b0;
    dac_cs_n  = 1'b1;
    dac_sclk  = 1'b0;
    dac_sdo   = 1'b0;
    unique case (r_state)
      IDLE: begin
        sum_ready = 1'b1;
        if (sum_valid)
          w_next = SHIFT;
      end
      SHIFT: begin
        dac_cs_n = 1'b0;
        dac_sclk = r_phase;
        dac_sdo  = r_shift[FRAME_W-1];
        if (w_last_bit)
          w_next = GAP;
      end
      GAP: begin
        if (w_gap_end)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Frame shift register, bit index and sclk phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
    end else if (w_accept) begin
      r_shift <= {DAC_CMD, scale_sum(sum_in)};
      r_bit   <= 4'd15;
      r_phase <= 1'b0;
    end else if (w_shift_en && w_tick) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
        r_bit   <= r_bit - 4'd1;
      end
    end
  end

  // Inter-frame gap counter
  always_ff @(posedge clk) begin
    if (rst)
      r_gap <= '0;
    else if (r_state == GAP)
      r_gap <= r_gap + 1'b1;
    else
      r_gap <= '0;
  end

  // Frame-complete pulse lands on the first IDLE cycle
  always_ff @(posedge clk) begin
    if (rst)
      r_done <= 1'b0;
    else
      r_done <= w_gap_end;
  end

  // Saturating overrun counter
  always_ff @(posedge clk) begin
    if (rst)
      r_drop <= '0;
    else if (sum_valid && (r_state != IDLE) && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign frame_done = r_done;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_sum_dac_spi.sv
// tb_sum_dac_spi: random and directed frames against a behavioural model.
// Instance A uses default timing, instance B uses CLK_DIV=1, GAP_CYC=1.
module tb_sum_dac_spi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_valid = 1'b0;
  logic [12:0] a_sum = '0;
  logic        a_ready, a_cs, a_sclk, a_sdo, a_done;
  logic [7:0]  a_drop;

  logic        b_valid = 1'b0;
  logic [12:0] b_sum = '0;
  logic        b_ready, b_cs, b_sclk, b_sdo, b_done;
  logic [7:0]  b_drop;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_dac_spi u_a (
    .clk        (clk),
    .rst        (rst),
    .sum_in     (a_sum),
    .sum_valid  (a_valid),
    .sum_ready  (a_ready),
    .dac_cs_n   (a_cs),
    .dac_sclk   (a_sclk),
    .dac_sdo    (a_sdo),
    .frame_done (a_done),
    .drop_cnt   (a_drop)
  );

  sum_dac_spi #(
    .CLK_DIV (1),
    .GAP_CYC (1),
    .DAC_CMD (4'h3)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .sum_in     (b_sum),
    .sum_valid  (b_valid),
    .sum_ready  (b_ready),
    .dac_cs_n   (b_cs),
    .dac_sclk   (b_sclk),
    .dac_sdo    (b_sdo),
    .frame_done (b_done),
    .drop_cnt   (b_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: frame = {cmd, scaled sample} from plain arithmetic
  function automatic logic [15:0] model_frame(input int s);
    int d;
`ifdef SUM_DAC_ROUND_EN
    d = (s + 1) / 2;
    if (d > 4095) d = 4095;
`else
    d = s / 2;
`endif
    return {4'h3, d[11:0]};
  endfunction

  task automatic drive(input int w, input logic v, input logic [12:0] s);
    if (w == 0) begin a_valid = v; a_sum = s; end
    else        begin b_valid = v; b_sum = s; end
  endtask

  function automatic logic g_rdy(input int w);
    return (w == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic g_cs(input int w);
    return (w == 0) ? a_cs : b_cs;
  endfunction
  function automatic logic g_sclk(input int w);
    return (w == 0) ? a_sclk : b_sclk;
  endfunction
  function automatic logic g_sdo(input int w);
    return (w == 0) ? a_sdo : b_sdo;
  endfunction
  function automatic logic g_done(input int w);
    return (w == 0) ? a_done : b_done;
  endfunction

  // Offer one sample, then watch the whole frame from the DAC pins
  task automatic send_frame(input int w, input logic [12:0] s,
                            input logic [15:0] exp);
    int cd, gap, to, csl, done_n, nbits;
    logic [15:0] cap;
    logic prev;
    cd  = (w == 0) ? 2 : 1;
    gap = (w == 0) ? 2 : 1;
    to = 0;
    @(negedge clk);
    while (!g_rdy(w) && to < 200) begin
      @(negedge clk);
      to++;
    end
    chk("accept_ready", g_rdy(w), 1);
    drive(w, 1'b1, s);
    @(posedge clk);
    #1 drive(w, 1'b0, 13'($urandom_range(0, 8191)));
    csl = 0; done_n = 0; nbits = 0; cap = '0; prev = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) chk("first_sdo", g_sdo(w), exp[15]);
      if (!g_cs(w)) csl++;
      if (g_sclk(w) && !prev) begin
        cap = {cap[14:0], g_sdo(w)};
        nbits++;
      end
      prev = g_sclk(w);
      drive(w, 1'b0, 13'($urandom_range(0, 8191)));
      if (g_done(w)) begin
        done_n = n;
        chk("done_ready", g_rdy(w), 1);
        break;
      end
    end
    chk("frame", cap, exp);
    chk("nbits", nbits, 16);
    chk("cs_low", csl, 32 * cd);
    chk("done_at", done_n, 32 * cd + gap + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, busy, mdrop;
    logic [12:0] s;

    // Reset and quiet idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", a_cs, 1);
    chk("rst_sclk", a_sclk, 0);
    chk("rst_sdo", a_sdo, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_drop", a_drop, 0);
    chk("rst_done", a_done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_cs !== 1'b1 || a_sclk !== 1'b0 || a_sdo !== 1'b0 ||
          a_ready !== 1'b1 || a_done !== 1'b0)
        bad++;
    end
    chk("idle_quiet", bad, 0);

    // Directed frames
    send_frame(0, 13'd8190, 16'h3FFF);
`ifdef SUM_DAC_ROUND_EN
    send_frame(0, 13'd4097, 16'h3801);
`else
    send_frame(0, 13'd4097, 16'h3800);
`endif
    send_frame(0, 13'd8191, 16'h3FFF);
    send_frame(0, 13'd0, 16'h3000);
    send_frame(1, 13'd1234, 16'h3269);

    // Random frames on both instances
    for (int i = 0; i < 12; i++) begin
      s = 13'($urandom_range(0, 8191));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(0, s, model_frame(int'(s)));
    end
    for (int i = 0; i < 4; i++) begin
      s = 13'($urandom_range(0, 8191));
      send_frame(1, s, model_frame(int'(s)));
    end
    chk("no_drops", a_drop, 0);

    // Overrun: valid held for 300 cycles, frames back to back
    busy = 0;
    mdrop = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 13'($urandom_range(0, 8191)));
      chk("ovr_ready", a_ready, (busy == 0) ? 1 : 0);
      chk("ovr_drop", a_drop, mdrop);
      @(posedge clk);
      if (busy == 0) begin
        busy = 66;
      end else begin
        busy--;
        if (mdrop < 255) mdrop++;
      end
    end
    @(negedge clk);
    drive(0, 1'b0, '0);
    chk("drop_sat", a_drop, 255);
    repeat (80) @(negedge clk);
    chk("drop_hold", a_drop, 255);

    // Reset mid-frame aborts and clears
    drive(0, 1'b1, 13'd4000);
    @(posedge clk);
    #1 drive(0, 1'b0, '0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs", a_cs, 1);
    chk("abort_sclk", a_sclk, 0);
    chk("abort_sdo", a_sdo, 0);
    chk("abort_ready", a_ready, 1);
    chk("abort_drop", a_drop, 0);
    rst = 1'b0;
    send_frame(0, 13'd2, 16'h3001);

    // Reset wins over a simultaneous valid
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 13'd5000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, '0);
    chk("rstv_cs", a_cs, 1);
    chk("rstv_drop", a_drop, 0);
    @(negedge clk);
    chk("rstv_idle", a_cs, 1);
    chk("rstv_ready", a_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
